// File: rtl/universal_shift_reg_pkg.sv
// rtl/universal_shift_reg_pkg.sv - mode encoding shared by the universal shift register
package universal_shift_reg_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    USR_HOLD = 3'b000,
    USR_SHR  = 3'b001,
    USR_SHL  = 3'b010,
    USR_LOAD = 3'b011,
    USR_ROR  = 3'b100,
    USR_ROL  = 3'b101,
    USR_ASR  = 3'b110,
    USR_INV  = 3'b111
  } usr_mode_e;

endpackage

// File: rtl/universal_shift_reg_next.sv
// rtl/universal_shift_reg_next.sv - next-value logic for the universal shift register
module universal_shift_reg_next
  import universal_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]  i_cur,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [WIDTH-1:0]  i_load,
  input  logic              i_sr_fill,
  input  logic              i_sl_fill,
  output logic [WIDTH-1:0]  o_next
);

  always_comb begin
    o_next = i_cur;
    case (usr_mode_e'(i_mode))
      USR_HOLD: o_next = i_cur;
      USR_SHR:  o_next = {i_sr_fill, i_cur[WIDTH-1:1]};
      USR_SHL:  o_next = {i_cur[WIDTH-2:0], i_sl_fill};
      USR_LOAD: o_next = i_load;
      USR_ROR:  o_next = {i_cur[0], i_cur[WIDTH-1:1]};
      USR_ROL:  o_next = {i_cur[WIDTH-2:0], i_cur[WIDTH-1]};
      USR_ASR:  o_next = {i_cur[WIDTH-1], i_cur[WIDTH-1:1]};
      USR_INV:  o_next = ~i_cur;
      default:  o_next = i_cur;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - register with asynchronous clear and selectable shift/rotate/load
// USR_SERIAL_IN_EN adds the sr_in/sl_in serial fill inputs; otherwise fills are zero.
module universal_shift_register
  import universal_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [MODE_W-1:0] S,
  input  logic [WIDTH-1:0]  I,
`ifdef USR_SERIAL_IN_EN
  input  logic              sr_in,
  input  logic              sl_in,
`endif
  output logic [WIDTH-1:0]  O
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_sr_fill;
  logic             w_sl_fill;

`ifdef USR_SERIAL_IN_EN
  assign w_sr_fill = sr_in;
  assign w_sl_fill = sl_in;
`else
  assign w_sr_fill = 1'b0;
  assign w_sl_fill = 1'b0;
`endif

  universal_shift_reg_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .i_cur     (r_q),
    .i_mode    (S),
    .i_load    (I),
    .i_sr_fill (w_sr_fill),
    .i_sl_fill (w_sl_fill),
    .o_next    (w_next)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) r_q <= '0;
    else        r_q <= w_next;
  end

  assign O = r_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - directed and randomized checks of universal_shift_register (WIDTH=4)
module tb_universal_shift_register;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clear;
  logic [2:0]   S;
  logic [W-1:0] I;
  logic [W-1:0] O;
  logic         sr_fill = 1'b0;
  logic         sl_fill = 1'b0;

  int total = 0;
  int bad   = 0;
  int m     = 0;

  always #5 clk = ~clk;

`ifdef USR_SERIAL_IN_EN
  universal_shift_register #(.WIDTH(W)) dut (
    .clk(clk), .clear(clear), .S(S), .I(I), .sr_in(sr_fill), .sl_in(sl_fill), .O(O)
  );
`else
  universal_shift_register #(.WIDTH(W)) dut (
    .clk(clk), .clear(clear), .S(S), .I(I), .O(O)
  );
`endif

  // Reference model: operations as plain integer arithmetic on the value.
  function automatic int ref_next(int v, int mode, int din, int srf, int slf);
    int msbw = 1 << (W - 1);
    int mask = (1 << W) - 1;
    case (mode)
      0: return v;
      1: return (v >> 1) | (srf * msbw);
      2: return ((v << 1) & mask) | slf;
      3: return din & mask;
      4: return (v >> 1) | ((v & 1) * msbw);
      5: return ((v << 1) & mask) | (v / msbw);
      6: return (v >> 1) | (v & msbw);
      default: return mask - v;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] exp);
    total++;
    assert (O === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, O, exp);
    end
  endtask

  task automatic apply(input logic [2:0] mode, input logic [W-1:0] data);
    S = mode;
    I = data;
    @(posedge clk);
    #1;
    m = ref_next(m, int'(mode), int'(data), int'(sr_fill), int'(sl_fill));
  endtask

  task automatic seq(input string tag, input logic [2:0] mode, input int n, input logic [15:0] exps);
    logic [15:0] e;
    e = exps;
    for (int k = 0; k < n; k++) begin
      apply(mode, 4'($urandom));
      check($sformatf("%s[%0d]", tag, k), e[15-4*k -: 4]);
    end
  endtask

  initial begin
    clear = 1'b0;
    S = 3'b011;
    I = 4'b1111;
    #1;
    check("reset_init", 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 4'b0000);

    clear = 1'b1;
    apply(3'b111, 4'b0101);
    check("first_edge_inv_of_zero", 4'b1111);

    apply(3'b011, 4'b1001);
    check("load", 4'b1001);
    for (int k = 0; k < 3; k++) begin
      apply(3'b000, 4'b0110);
      check("hold", 4'b1001);
    end

    #3 clear = 1'b0;
    #1 check("async_clear_midcycle", 4'b0000);
    m = 0;
    apply(3'b011, 4'b1111);
    check("clear_low_ignores_edge", 4'b0000);
    clear = 1'b1;

    apply(3'b011, 4'b1001);
    seq("ror", 3'b100, 4, 16'b1100_0110_0011_1001);
    apply(3'b011, 4'b1001);
    seq("rol", 3'b101, 3, 16'b0011_0110_1100_0000);
    apply(3'b011, 4'b1001);
    seq("asr", 3'b110, 3, 16'b1100_1110_1111_0000);
    apply(3'b011, 4'b1001);
    seq("inv", 3'b111, 2, 16'b0110_1001_0000_0000);
    apply(3'b011, 4'b1001);
    seq("shr", 3'b001, 4, 16'b0100_0010_0001_0000);
    apply(3'b011, 4'b1001);
    seq("shl", 3'b010, 4, 16'b0010_0100_1000_0000);
    apply(3'b011, 4'b0000);
    seq("zero_ror", 3'b100, 1, 16'b0000_0000_0000_0000);
    apply(3'b011, 4'b1001);
    apply(3'b100, 4'b0000); check("mix_ror", 4'b1100);
    apply(3'b111, 4'b0000); check("mix_inv", 4'b0011);
    apply(3'b110, 4'b0000); check("mix_asr", 4'b0001);
    apply(3'b101, 4'b0000); check("mix_rol", 4'b0010);
    apply(3'b010, 4'b0000); check("mix_shl", 4'b0100);
    apply(3'b001, 4'b0000); check("mix_shr", 4'b0010);
    apply(3'b000, 4'b0000); check("mix_hold", 4'b0010);

`ifdef USR_SERIAL_IN_EN
    apply(3'b011, 4'b0000);
    sr_fill = 1'b1;
    seq("shr_serial", 3'b001, 2, 16'b1000_1100_0000_0000);
    sr_fill = 1'b0;
    apply(3'b011, 4'b0000);
    sl_fill = 1'b1;
    seq("shl_serial", 3'b010, 2, 16'b0001_0011_0000_0000);
    sl_fill = 1'b0;
`endif

    m = int'(O);
    for (int k = 0; k < 300; k++) begin
`ifdef USR_SERIAL_IN_EN
      sr_fill = 1'($urandom);
      sl_fill = 1'($urandom);
`endif
      if ($urandom_range(0, 24) == 0) begin
        #2 clear = 1'b0;
        #1 check("rand_clear", 4'b0000);
        m = 0;
        @(negedge clk);
        clear = 1'b1;
      end
      apply(3'($urandom_range(0, 7)), 4'($urandom));
      check($sformatf("rand[%0d] S=%b", k, S), 4'(m));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
